// File: rtl/apb_requester_mc.sv
// rtl/apb_requester_mc.sv - APB4 requester with address decode, PSTRB, error reporting and wait-state timeout
module apb_requester_mc #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [DATA_W/8-1:0]         req_strb,
    output logic                        resp_valid,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        resp_err,
    output logic [ADDR_W-1:0]           PADDR,
    output logic                        PWRITE,
    output logic [DATA_W-1:0]           PWDATA,
    output logic [DATA_W/8-1:0]         PSTRB,
    output logic [NUM_SLV-1:0]          PSELx,
    output logic                        PENABLE,
    input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
    input  logic [NUM_SLV-1:0]          PREADY,
    input  logic [NUM_SLV-1:0]          PSLVERR
);

    localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DERR
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [31:0]         wait_cnt;
    logic [SW-1:0]       req_idx;
    logic [NUM_SLV-1:0]  req_sel;
    logic                req_hit;
    logic                sel_ready;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;
    logic                accept;
    logic                done;
    logic                abort;

    // Decode the incoming request address into a one-hot completer select
    always_comb begin
        req_idx = req_addr[SEL_LSB +: SW];
        req_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            req_sel[i] = (req_idx == SW'(i));
        end
        req_hit = |req_sel;
    end

    // Observe only the selected completer; the registered one-hot PSELx is the mux select
    always_comb begin
        sel_ready = |(PREADY & PSELx);
        sel_err   = |(PSLVERR & PSELx);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (PSELx[i]) begin
                sel_rdata = sel_rdata | PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and handshake decisions
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_hit ? S_SETUP : S_DERR;
                end
            end
            S_SETUP: begin
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (sel_ready) begin
                    done      = 1'b1;
                    req_ready = 1'b1;
                    if (req_valid) begin
                        accept    = 1'b1;
                        state_nxt = req_hit ? S_SETUP : S_DERR;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if ((TIMEOUT > 0) && (wait_cnt == 32'(TIMEOUT - 1))) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DERR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // APB bus outputs: request latched at acceptance, held stable until completion
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            PSELx   <= '0;
            PENABLE <= 1'b0;
        end else if (accept) begin
            PADDR   <= req_addr;
            PWRITE  <= req_write;
            PWDATA  <= req_wdata;
            PSTRB   <= (req_write && req_hit) ? req_strb : '0;
            PSELx   <= req_hit ? req_sel : '0;
            PENABLE <= 1'b0;
        end else if (state == S_SETUP) begin
            PENABLE <= 1'b1;
        end else if (done || abort) begin
            PSELx   <= '0;
            PENABLE <= 1'b0;
            PSTRB   <= '0;
        end
    end

    // Consecutive wait-state counter, cleared whenever a new transfer is accepted
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == S_ACCESS) && !sel_ready) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end

    // One registered response per request: completion, timeout abort or decode error
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= done || abort || (state == S_DERR);
            resp_err   <= abort || (state == S_DERR) || (done && sel_err);
            resp_rdata <= (done && !PWRITE && !sel_err) ? sel_rdata : '0;
        end
    end

endmodule
